// File: rtl/sc_pkg.sv
// sc_pkg: shared defaults, mode encoding and width helpers for the stochastic-computing datapath
package sc_pkg;

    localparam int SC_BITSTREAM = 64;
    localparam int SC_QUANT     = 8;

    typedef enum logic {SC_UNIPOLAR, SC_BIPOLAR} sc_mode_e;

    // Accumulator width: popcount range, plus growth over max_len terms, plus a sign bit
    function automatic int sc_acc_w(input int bitstream, input int max_len);
        return $clog2(bitstream + 1) + $clog2(max_len) + 1;
    endfunction

endpackage

// File: rtl/sc_popcount.sv
// sc_popcount: combinational ones-count built as a balanced adder tree of half-width counts
module sc_popcount #(
    parameter int W = 64
) (
    input  logic [W-1:0]             bits,
    output logic [$clog2(W+1)-1:0]   count
);

    localparam int OW = $clog2(W + 1);

    generate
        if (W == 1) begin : g_leaf
            assign count = bits;
        end else begin : g_node
            localparam int LW = W / 2;
            localparam int HW = W - W / 2;
            logic [$clog2(LW+1)-1:0] lo;
            logic [$clog2(HW+1)-1:0] hi;
            sc_popcount #(.W(LW)) u_lo (.bits(bits[LW-1:0]), .count(lo));
            sc_popcount #(.W(HW)) u_hi (.bits(bits[W-1:LW]), .count(hi));
            assign count = OW'(lo) + OW'(hi);
        end
    endgenerate

endmodule

// File: rtl/sc_bitstream_mac.sv
// sc_bitstream_mac: bitwise stochastic multiply, popcount and per-vector signed accumulation
module sc_bitstream_mac
    import sc_pkg::*;
#(
    parameter int BITSTREAM = SC_BITSTREAM,
    parameter int MAX_LEN   = 256,
    parameter int BIPOLAR   = 1,
    parameter int CNT_W     = $clog2(MAX_LEN + 1),
    parameter int ACC_W     = sc_acc_w(BITSTREAM, MAX_LEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BITSTREAM-1:0] in_a,
    input  logic [BITSTREAM-1:0] in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_sum,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_overflow
);

    localparam int       PC_W = $clog2(BITSTREAM + 1);
    localparam sc_mode_e MODE = (BIPOLAR != 0) ? SC_BIPOLAR : SC_UNIPOLAR;

    logic                 advance;
    logic                 accept;
    logic                 fire;
    logic [BITSTREAM-1:0] p_bits;
    logic                 p_last;
    logic                 p_valid;
    logic [PC_W-1:0]      pc;
    logic [ACC_W-1:0]     term;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     acc_next;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic                 ovf;
    logic                 ovf_next;

    // A pending result that is not being taken freezes the whole pipeline
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = rst_n && advance;
    assign accept   = in_valid && in_ready;
    assign fire     = p_valid && advance;

    sc_popcount #(.W(BITSTREAM)) u_popcount (
        .bits  (p_bits),
        .count (pc)
    );

    // Bipolar terms map popcount 0..N onto -N..+N; unipolar terms are the raw popcount
    assign term     = (MODE == SC_BIPOLAR) ? ACC_W'({pc, 1'b0}) - ACC_W'(BITSTREAM) : ACC_W'(pc);
    assign acc_next = acc + term;
    assign cnt_next = (cnt == CNT_W'(MAX_LEN)) ? cnt : cnt + CNT_W'(1);
    assign ovf_next = ovf | (cnt == CNT_W'(MAX_LEN));

    // S1: register the bitwise product of the two streams
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            p_last  <= 1'b0;
            p_bits  <= '0;
        end else if (advance) begin
            p_valid <= accept;
            if (accept) begin
                p_bits <= (MODE == SC_BIPOLAR) ? ~(in_a ^ in_b) : (in_a & in_b);
                p_last <= in_last;
            end
        end
    end

    // S2: accumulate terms; a last beat clears state so the next vector starts with no bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (fire) begin
            acc <= p_last ? '0 : acc_next;
            cnt <= p_last ? '0 : cnt_next;
            ovf <= !p_last && ovf_next;
        end
    end

    // Output register: load on a finished vector, drop valid once consumed with nothing new
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else if (fire && p_last) begin
            out_valid    <= 1'b1;
            out_sum      <= acc_next;
            out_count    <= cnt_next;
            out_overflow <= ovf_next;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/sc_bitstream_mac.md
Name: sc_bitstream_mac

Overview:
- Downstream consumer of the SNG stage in the stochastic-computing datapath.
- Takes two BITSTREAM-wide stochastic bitstreams per beat, typically an activation and a weight from two SNG instances.
- Multiplies them bitwise: XNOR in bipolar mode, AND in unipolar mode.
- Popcounts the product and accumulates a signed per-term value over a vector delimited by in_last.
- Emits one binary dot-product result per vector on a valid/ready output.

Parameters:
- BITSTREAM, 64, bits per stochastic stream; must match the upstream SNG.
- MAX_LEN, 256, maximum terms per vector before out_overflow is flagged.
- BIPOLAR, 1, 1 = XNOR product with term 2*pc-BITSTREAM; 0 = AND product with term pc.
- CNT_W, $clog2(MAX_LEN+1), term-counter width.
- ACC_W, $clog2(BITSTREAM+1)+$clog2(MAX_LEN)+1, signed accumulator and result width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready at posedge clk
- in_a  in  BITSTREAM  stream A, the SNG r_bitstream
- in_b  in  BITSTREAM  stream B
- in_last  in  1  final term of the current vector
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready at posedge clk
- out_sum  out  ACC_W  signed accumulated dot product, in stochastic units
- out_count  out  CNT_W  number of terms in the vector
- out_overflow  out  1  vector exceeded MAX_LEN terms

Behaviour:
- Reset: one clock, synchronous, active-low. All state and outputs are 0 while rst_n is low and on the first cycle after: out_valid=0, out_sum=0, out_count=0, out_overflow=0, accumulator=0, counter=0, S1 empty. in_ready=0 while rst_n is low.
- Stall and ready: advance = !(out_valid && !out_ready). in_ready = rst_n && advance (combinational). The whole pipeline freezes when advance=0.
- S1 (product register):
  - On acceptance: p_bits <= BIPOLAR ? ~(in_a^in_b) : (in_a&in_b); p_last <= in_last; p_valid <= 1.
  - On an advance cycle with no acceptance: p_valid <= 0.
- S2 (accumulate), runs when p_valid && advance:
  - pc = popcount(p_bits), range 0..BITSTREAM.
  - term = BIPOLAR ? 2*pc - BITSTREAM : pc, sign-extended to ACC_W.
  - Not last: acc <= acc+term; cnt <= cnt+1 (saturating at MAX_LEN); ovf <= ovf | (cnt==MAX_LEN).
  - Last:
    - out_sum <= acc+term; out_count <= cnt+1 (saturating); out_overflow <= ovf | (cnt==MAX_LEN); out_valid <= 1.
    - acc, cnt and ovf reset to 0, so the next vector starts clean on the following beat, with no bubble.
- Output: if out_valid && out_ready and no new result this cycle, out_valid <= 0. A result consumed on the same cycle a new result is produced is replaced; no bubble. out_sum, out_count and out_overflow stay stable while out_valid=1 and out_ready=0.
- Latency and throughput: a last beat accepted at edge N gives out_valid=1 after edge N+1. Throughput is 1 beat/cycle absent backpressure.
- Arithmetic: two's complement. Overflowed vectors wrap modulo 2^ACC_W and are flagged, not saturated.
- Single-term vector: in_last on the first beat gives out_count=1.
- Reset mid-vector: partial accumulation, S1 contents and any pending output are discarded.
- Valid-high beats with in_last=0 never produce output on their own.

Decomposition:
- Package sc_pkg holds:
  - SC_BITSTREAM=64 and SC_QUANT=8 defaults shared with SNG;
  - typedef enum {SC_UNIPOLAR, SC_BIPOLAR} sc_mode_e;
  - function sc_acc_w(bitstream, max_len).
- Sub-module sc_popcount (parameter W): a combinational adder tree, output width $clog2(W+1). Reused by other stochastic-to-binary stages.

Test Plan (BITSTREAM=64, BIPOLAR=1 unless stated):
- Single beat: in_a=all-ones, in_b=all-ones, last=1, accepted at edge N -> out_valid after N+1, out_sum=+64, out_count=1, out_overflow=0.
- 4-beat vector, back-to-back, terms in order:
  - (ones, ones) -> +64
  - (ones, zeros) -> -64
  - (0x5555…5555, all-ones) -> 0
  - (ones, ones) -> +64, with last on this beat
  - Required: out_sum=+64, out_count=4; a second vector starting the next cycle is unaffected.
- Backpressure: hold out_ready=0 with a result pending -> in_ready=0, output stable for 5 cycles, three subsequent beats stall. Raise out_ready -> result consumed, stalled beats complete, no loss or duplication.
- Unipolar, BIPOLAR=0: three beats of in_a=0xFF, in_b=0x0F (upper bits 0), last on the third -> out_sum=12, out_count=3.
- Reset mid-vector: accumulate 2 beats of (ones, ones), drop rst_n for one cycle, then one last beat of (ones, ones) -> out_sum=+64, out_count=1.
- Overflow, MAX_LEN=4: 5 beats of (ones, zeros), last on the 5th -> out_overflow=1, out_count=4. The next vector reports out_overflow=0.
